// File: rtl/tdm_pkg.sv
`default_nettype none
// ============================================================================
// Module   : tdm_pkg
// Purpose  : Shared types and sizing helpers for the TDM mux/demux pair.
// Revision : 1.0 - initial release
// ============================================================================
package tdm_pkg;

    typedef enum logic [0:0] {
        HUNT   = 1'b0,
        LOCKED = 1'b1
    } tdm_state_e;

    localparam int DEF_NUM_CH = 4;
    localparam int DEF_WORD_W = 8;

    // Width of a counter spanning 0..range-1, never narrower than one bit.
    function automatic int cnt_w(input int range);
        return (range <= 2) ? 1 : $clog2(range);
    endfunction

endpackage : tdm_pkg
`default_nettype wire

// File: rtl/tdm_demux_if.sv
`default_nettype none
// ============================================================================
// Module   : tdm_demux_if
// Purpose  : Serial input and de-interleaved output bundle of the TDM demux.
// Revision : 1.0 - initial release
// ============================================================================
interface tdm_demux_if
    import tdm_pkg::*;
#(
    parameter int NUM_CH = DEF_NUM_CH,
    parameter int WORD_W = DEF_WORD_W
);
    logic                       in_valid;
    logic                       in_bit;
    logic                       frame_sync;
    logic [NUM_CH*WORD_W-1:0]   out_data;
    logic [NUM_CH-1:0]          out_valid;
    logic                       locked;
    logic                       sync_err;

    modport master (
        output in_valid, in_bit, frame_sync,
        input  out_data, out_valid, locked, sync_err
    );

    modport slave (
        input  in_valid, in_bit, frame_sync,
        output out_data, out_valid, locked, sync_err
    );
endinterface : tdm_demux_if
`default_nettype wire

// File: rtl/tdm_slot_counter.sv
`default_nettype none
// ============================================================================
// Module   : tdm_slot_counter
// Purpose  : Bit-within-word and channel-within-frame position counters.
// Revision : 1.0 - initial release
// ============================================================================
module tdm_slot_counter
    import tdm_pkg::*;
#(
    parameter int NUM_CH = DEF_NUM_CH,
    parameter int WORD_W = DEF_WORD_W,
    parameter int BW     = cnt_w(WORD_W),
    parameter int CW     = cnt_w(NUM_CH)
) (
    input  wire logic          clk,
    input  wire logic          rst,
    input  wire logic          advance,
    input  wire logic          clear,
    input  wire logic          load_first,
    output logic [BW-1:0]      bit_cnt,
    output logic [CW-1:0]      ch_cnt,
    output logic               word_last,
    output logic               frame_start
);
    localparam logic [BW-1:0] BIT_LAST = BW'(WORD_W - 1);
    localparam logic [CW-1:0] CH_LAST  = CW'(NUM_CH - 1);

    logic [BW-1:0] bit_cnt_q, bit_cnt_d;
    logic [CW-1:0] ch_cnt_q,  ch_cnt_d;

    // load_first marks the current beat as ch 0 bit 0, so the next position is bit 1.
    always_comb begin
        bit_cnt_d = bit_cnt_q;
        ch_cnt_d  = ch_cnt_q;
        if (clear) begin
            bit_cnt_d = '0;
            ch_cnt_d  = '0;
        end else if (load_first) begin
            bit_cnt_d = BW'(1);
            ch_cnt_d  = '0;
        end else if (advance) begin
            if (bit_cnt_q == BIT_LAST) begin
                bit_cnt_d = '0;
                ch_cnt_d  = (ch_cnt_q == CH_LAST) ? '0 : ch_cnt_q + CW'(1);
            end else begin
                bit_cnt_d = bit_cnt_q + BW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bit_cnt_q <= '0;
            ch_cnt_q  <= '0;
        end else begin
            bit_cnt_q <= bit_cnt_d;
            ch_cnt_q  <= ch_cnt_d;
        end
    end

    assign bit_cnt     = bit_cnt_q;
    assign ch_cnt      = ch_cnt_q;
    assign word_last   = (bit_cnt_q == BIT_LAST);
    assign frame_start = (bit_cnt_q == '0) && (ch_cnt_q == '0);
endmodule : tdm_slot_counter
`default_nettype wire

// File: rtl/tdm_demux.sv
`default_nettype none
// ============================================================================
// Module   : tdm_demux
// Purpose  : Frame-aligns a serial TDM stream and splits it into channel words.
// Revision : 1.0 - initial release
// ============================================================================
module tdm_demux
    import tdm_pkg::*;
#(
    parameter int NUM_CH = DEF_NUM_CH,
    parameter int WORD_W = DEF_WORD_W
) (
    input  wire logic   clk,
    input  wire logic   rst,
    tdm_demux_if.slave  bus
);
    localparam int BW = cnt_w(WORD_W);
    localparam int CW = cnt_w(NUM_CH);

    tdm_state_e                state_q, state_d;
    logic [WORD_W-2:0]         shift_q, shift_d;
    logic [NUM_CH*WORD_W-1:0]  out_data_q, out_data_d;
    logic [NUM_CH-1:0]         out_valid_q, out_valid_d;
    logic                      locked_q, locked_d;
    logic                      sync_err_q, sync_err_d;

    logic                      w_advance, w_clear, w_load_first;
    logic [BW-1:0]             w_bit_cnt;
    logic [CW-1:0]             w_ch_cnt;
    logic                      w_word_last, w_frame_start;
    logic [WORD_W-1:0]         w_word;

    tdm_slot_counter #(
        .NUM_CH (NUM_CH),
        .WORD_W (WORD_W),
        .BW     (BW),
        .CW     (CW)
    ) u_slot_counter (
        .clk         (clk),
        .rst         (rst),
        .advance     (w_advance),
        .clear       (w_clear),
        .load_first  (w_load_first),
        .bit_cnt     (w_bit_cnt),
        .ch_cnt      (w_ch_cnt),
        .word_last   (w_word_last),
        .frame_start (w_frame_start)
    );

    // Only WORD_W-1 history bits are kept; the final bit comes straight from the line.
    assign w_word = {shift_q, bus.in_bit};

    always_comb begin
        state_d      = state_q;
        shift_d      = shift_q;
        out_data_d   = out_data_q;
        out_valid_d  = '0;
        sync_err_d   = 1'b0;
        w_advance    = 1'b0;
        w_clear      = 1'b0;
        w_load_first = 1'b0;
        if (bus.in_valid) begin
            case (state_q)
                HUNT: begin
                    if (bus.frame_sync) begin
                        w_load_first = 1'b1;
                        shift_d      = '0;
                        shift_d[0]   = bus.in_bit;
                        state_d      = LOCKED;
                    end
                end
                LOCKED: begin
                    if (w_frame_start && !bus.frame_sync) begin
                        sync_err_d = 1'b1;
                        w_clear    = 1'b1;
                        state_d    = HUNT;
                    end else if (!w_frame_start && bus.frame_sync) begin
                        // Early marker: drop the partial word and restart the frame here.
                        sync_err_d   = 1'b1;
                        w_load_first = 1'b1;
                        shift_d      = '0;
                        shift_d[0]   = bus.in_bit;
                    end else begin
                        w_advance = 1'b1;
                        shift_d   = w_word[WORD_W-2:0];
                        if (w_word_last) begin
                            out_data_d[int'(w_ch_cnt)*WORD_W +: WORD_W] = w_word;
                            out_valid_d[w_ch_cnt] = 1'b1;
                        end
                    end
                end
                default: state_d = HUNT;
            endcase
        end
        locked_d = (state_d == LOCKED);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= HUNT;
            shift_q     <= '0;
            out_data_q  <= '0;
            out_valid_q <= '0;
            locked_q    <= 1'b0;
            sync_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            shift_q     <= shift_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            locked_q    <= locked_d;
            sync_err_q  <= sync_err_d;
        end
    end

    assign bus.out_data  = out_data_q;
    assign bus.out_valid = out_valid_q;
    assign bus.locked    = locked_q;
    assign bus.sync_err  = sync_err_q;
endmodule : tdm_demux
`default_nettype wire

// File: tb/tb_tdm_demux.sv
`default_nettype none
// ============================================================================
// Module   : tb_tdm_demux
// Purpose  : Self-checking bench for tdm_demux (NUM_CH=4, WORD_W=8).
// Revision : 1.0 - initial release
// ============================================================================
module tb_tdm_demux;
    import tdm_pkg::*;

    localparam int NUM_CH     = 4;
    localparam int WORD_W     = 8;
    localparam int FRAME_BITS = NUM_CH * WORD_W;

    logic clk = 1'b0;
    logic rst;

    tdm_demux_if #(.NUM_CH(NUM_CH), .WORD_W(WORD_W)) bus ();

    tdm_demux #(.NUM_CH(NUM_CH), .WORD_W(WORD_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: alignment flag plus bit position inside the frame.
    bit                 m_aligned;
    int                 m_pos;
    logic [WORD_W-1:0]  m_acc;
    logic [WORD_W-1:0]  m_word [NUM_CH];
    logic [NUM_CH-1:0]  m_valid;
    bit                 m_err;

    // Observation log for the current scenario.
    int cyc;
    int pulse_cnt [NUM_CH];
    int pulse_cyc [NUM_CH];
    int err_cnt;

    typedef struct {
        string       name;
        bit          do_reset;
        int          garbage;
        bit          gapped;
        logic [31:0] words;
        logic [31:0] exp_data;
        int          exp_first;
        int          exp_space;
    } vec_t;

    vec_t vecs [3];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_aligned = 1'b0;
        m_pos     = 0;
        m_acc     = '0;
        m_valid   = '0;
        m_err     = 1'b0;
        for (int k = 0; k < NUM_CH; k++) m_word[k] = '0;
    endtask

    function automatic logic [FRAME_BITS-1:0] m_data();
        logic [FRAME_BITS-1:0] d;
        for (int k = 0; k < NUM_CH; k++) d[k*WORD_W +: WORD_W] = m_word[k];
        return d;
    endfunction

    task automatic model_beat(input bit v, input bit b, input bit fs);
        m_valid = '0;
        m_err   = 1'b0;
        if (v) begin
            if (!m_aligned) begin
                if (fs) begin
                    m_aligned = 1'b1;
                    m_acc     = '0;
                    m_acc[0]  = b;
                    m_pos     = 1;
                end
            end else if (m_pos == 0 && !fs) begin
                m_err     = 1'b1;
                m_aligned = 1'b0;
            end else if (m_pos != 0 && fs) begin
                m_err    = 1'b1;
                m_acc    = '0;
                m_acc[0] = b;
                m_pos    = 1;
            end else begin
                m_acc = {m_acc[WORD_W-2:0], b};
                m_pos++;
                if (m_pos % WORD_W == 0) begin
                    m_word[m_pos/WORD_W - 1]  = m_acc;
                    m_valid[m_pos/WORD_W - 1] = 1'b1;
                end
                if (m_pos == FRAME_BITS) m_pos = 0;
            end
        end
    endtask

    task automatic clear_log();
        cyc     = 0;
        err_cnt = 0;
        for (int k = 0; k < NUM_CH; k++) begin
            pulse_cnt[k] = 0;
            pulse_cyc[k] = 0;
        end
    endtask

    task automatic step(input bit v, input bit b, input bit fs);
        @(negedge clk);
        bus.in_valid   = v;
        bus.in_bit     = b;
        bus.frame_sync = fs;
        model_beat(v, b, fs);
        @(posedge clk);
        #1;
        cyc++;
        check("out_data",  64'(bus.out_data),  64'(m_data()));
        check("out_valid", 64'(bus.out_valid), 64'(m_valid));
        check("locked",    64'(bus.locked),    64'(m_aligned));
        check("sync_err",  64'(bus.sync_err),  64'(m_err));
        for (int k = 0; k < NUM_CH; k++) begin
            if (bus.out_valid[k]) begin
                pulse_cnt[k]++;
                pulse_cyc[k] = cyc + 1;
            end
        end
        if (bus.sync_err) err_cnt++;
    endtask

    task automatic send_word(input logic [WORD_W-1:0] w, input bit gapped, input bit first_fs);
        for (int i = WORD_W - 1; i >= 0; i--) begin
            step(1'b1, w[i], first_fs && (i == WORD_W - 1));
            if (gapped) step(1'b0, 1'($urandom_range(1)), 1'($urandom_range(1)));
        end
    endtask

    task automatic send_frame(input logic [31:0] words, input bit gapped);
        for (int k = 0; k < NUM_CH; k++) send_word(words[k*WORD_W +: WORD_W], gapped, k == 0);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b1;
        model_reset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] tmp;
        int          tx_pos;
        bit          v, fs;

        vecs[0] = '{"garbage_then_frame", 1'b1, 13, 1'b0, 32'h12345678, 32'h12345678, 9, 8};
        vecs[1] = '{"normal_frame",       1'b0,  0, 1'b0, 32'h01FF3CA5, 32'h01FF3CA5, 9, 8};
        vecs[2] = '{"gapped_frame",       1'b0,  0, 1'b1, 32'h01FF3CA5, 32'h01FF3CA5, 16, 16};

        rst            = 1'b1;
        bus.in_valid   = 1'b0;
        bus.in_bit     = 1'b0;
        bus.frame_sync = 1'b0;
        model_reset();
        #1;
        check("reset_out_data",  64'(bus.out_data),  64'h0);
        check("reset_out_valid", 64'(bus.out_valid), 64'h0);
        check("reset_locked",    64'(bus.locked),    64'h0);
        check("reset_sync_err",  64'(bus.sync_err),  64'h0);
        #16;
        rst = 1'b0;

        for (int r = 0; r < 3; r++) begin
            if (vecs[r].do_reset) apply_reset();
            clear_log();
            for (int g = 0; g < vecs[r].garbage; g++) step(1'b1, 1'($urandom_range(1)), 1'b0);
            for (int k = 0; k < NUM_CH; k++)
                check({vecs[r].name, "_pre_pulses"}, 64'(pulse_cnt[k]), 64'd0);
            check({vecs[r].name, "_pre_err"}, 64'(err_cnt), 64'd0);
            clear_log();
            send_frame(vecs[r].words, vecs[r].gapped);
            check({vecs[r].name, "_data"}, 64'(bus.out_data), 64'(vecs[r].exp_data));
            check({vecs[r].name, "_locked"}, 64'(bus.locked), 64'd1);
            check({vecs[r].name, "_err"}, 64'(err_cnt), 64'd0);
            for (int k = 0; k < NUM_CH; k++) begin
                check({vecs[r].name, "_pulse_cnt"}, 64'(pulse_cnt[k]), 64'd1);
                check({vecs[r].name, "_pulse_cyc"}, 64'(pulse_cyc[k]),
                      64'(vecs[r].exp_first + k * vecs[r].exp_space));
            end
        end

        // Missing sync at the start of the next frame.
        clear_log();
        step(1'b1, 1'b0, 1'b0);
        check("miss_err_now", 64'(bus.sync_err), 64'd1);
        check("miss_unlocked", 64'(bus.locked), 64'd0);
        check("miss_data_kept", 64'(bus.out_data), 64'h01FF3CA5);
        for (int i = 0; i < 5; i++) step(1'b1, 1'($urandom_range(1)), 1'b0);
        send_frame(32'h44332211, 1'b0);
        check("miss_err_cnt", 64'(err_cnt), 64'd1);
        check("miss_relock_data", 64'(bus.out_data), 64'h44332211);
        check("miss_relocked", 64'(bus.locked), 64'd1);

        // Early sync at ch 2 bit 3.
        clear_log();
        send_word(8'h5A, 1'b0, 1'b1);
        send_word(8'hC3, 1'b0, 1'b0);
        tmp = 32'h0000000F;
        for (int i = 7; i > 4; i--) step(1'b1, tmp[i], 1'b0);
        send_frame(32'hEFBEADDE, 1'b0);
        check("early_err_cnt", 64'(err_cnt), 64'd1);
        check("early_ch2_pulses", 64'(pulse_cnt[2]), 64'd1);
        check("early_ch0_pulses", 64'(pulse_cnt[0]), 64'd2);
        check("early_data", 64'(bus.out_data), 64'hEFBEADDE);

        // Asynchronous reset at ch 1 bit 4.
        clear_log();
        send_word(8'h9C, 1'b0, 1'b1);
        tmp = 32'h0000006B;
        for (int i = 7; i > 3; i--) step(1'b1, tmp[i], 1'b0);
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        check("arst_out_data",  64'(bus.out_data),  64'h0);
        check("arst_out_valid", 64'(bus.out_valid), 64'h0);
        check("arst_locked",    64'(bus.locked),    64'h0);
        check("arst_sync_err",  64'(bus.sync_err),  64'h0);
        @(posedge clk);
        #3;
        rst = 1'b0;
        clear_log();
        for (int i = 0; i < 40; i++) step(1'b1, 1'($urandom_range(1)), 1'b0);
        check("arst_no_pulses", 64'(pulse_cnt[0] + pulse_cnt[1] + pulse_cnt[2] + pulse_cnt[3]), 64'd0);
        check("arst_hunt", 64'(bus.locked), 64'd0);
        send_frame(32'h01FF3CA5, 1'b0);
        check("arst_relock_data", 64'(bus.out_data), 64'h01FF3CA5);

        // Randomized traffic: mostly well-framed, with occasional sync faults.
        tx_pos = 0;
        for (int i = 0; i < 2000; i++) begin
            v  = ($urandom_range(3) != 0);
            fs = (tx_pos % FRAME_BITS == 0);
            if ($urandom_range(59) == 0) fs = ~fs;
            step(v, 1'($urandom_range(1)), fs);
            if (v) tx_pos++;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule : tb_tdm_demux
`default_nettype wire

// File: doc/tdm_demux.md
Name: tdm_demux

Overview:
- Receiving end of the team's time-division serial link; the counterpart of the mux-side framer that interleaves several channel words onto one bit stream.
- Takes a qualified serial bit stream with a frame-sync marker and de-interleaves it into NUM_CH parallel words.
- Raises a per-channel valid pulse as each word completes.
- Sits between the serial link front end and the per-channel consumers.

Parameters:
- NUM_CH, 4, number of channels (slots) per frame, must be >= 2
- WORD_W, 8, bits per channel word, must be >= 2

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  qualifies in_bit and frame_sync for this cycle
- in_bit  input  1  serial data bit; each word is sent MSB first
- frame_sync  input  1  high, with in_valid, on the first bit of channel 0 of a frame
- out_data  output  NUM_CH*WORD_W  channel k word held in bits [k*WORD_W +: WORD_W]
- out_valid  output  NUM_CH  one-cycle pulse on bit k when the channel k word updates
- locked  output  1  high while the block is frame-aligned
- sync_err  output  1  one-cycle pulse when a framing violation is detected

Behaviour:
- Reset (asynchronous, immediate): state HUNT, all counters 0, shift register 0, out_data 0, out_valid 0, locked 0, sync_err 0.
- Frame format: NUM_CH consecutive slots, channel 0 first; each slot is WORD_W bits, MSB first. Only cycles with in_valid=1 advance anything. With in_valid=0, counters, shift register and state hold, and frame_sync and in_bit are ignored.
- Counters:
  - bit_cnt runs 0..WORD_W-1.
  - ch_cnt runs 0..NUM_CH-1.
  - When bit_cnt=WORD_W-1, bit_cnt wraps to 0 and ch_cnt increments.
  - When ch_cnt=NUM_CH-1 and bit_cnt wraps, ch_cnt wraps to 0 (frame boundary).
  - Counter widths are clog2 of their range, minimum 1.
- HUNT:
  - Bits are discarded until a valid beat with frame_sync=1 arrives.
  - That beat is taken as ch 0 bit 0. It is shifted in, bit_cnt becomes 1, ch_cnt becomes 0, and the state moves to LOCKED.
  - locked goes high on the following cycle.
- LOCKED:
  - Each valid beat shifts in_bit into the shift register LSB, so earlier bits move toward the MSB.
  - On the beat where bit_cnt=WORD_W-1, the complete word (shift register contents plus in_bit) is written to the ch_cnt slice of out_data, and out_valid[ch_cnt] pulses. Both are registered and visible the cycle after that beat (latency 1 clock from the last bit).
  - Other channel slices hold their values.
- Expected sync position: ch_cnt=0 and bit_cnt=0.
  - frame_sync=1 at that position: normal, continue.
  - frame_sync=0 at that position: sync_err pulses. The state returns to HUNT, the beat is discarded, counters clear and locked drops. out_data is retained.
  - frame_sync=1 at any other position: sync_err pulses. The partial word is discarded with no out_valid. The beat is treated as a new ch 0 bit 0 and the state stays LOCKED (re-align in place).
- Outputs:
  - At most one out_valid bit is high in any cycle.
  - out_valid and sync_err are never high in the same cycle.
- Reset in mid-frame clears everything immediately. No out_valid fires for the partial word.

Decomposition:
- Shared package tdm_pkg holds:
  - the state typedef {HUNT, LOCKED}
  - the default NUM_CH and WORD_W constants
  - a clog2-based width helper
- The mux-side framer uses the same package.
- One sub-module, tdm_slot_counter:
  - contains the bit_cnt/ch_cnt pair
  - inputs: advance, clear, load_first
  - outputs: bit_cnt, ch_cnt, word_last, frame_start
- The top level holds the state machine, the shift register and the output registers.

Test Plan:
(All scenarios use NUM_CH=4, WORD_W=8.)
1. Normal frame: send frame_sync on the first beat, then words 8'hA5, 8'h3C, 8'hFF, 8'h01 with in_valid=1 continuously. Required response: out_valid[0..3] pulse at cycles 9, 17, 25, 33 after the first beat; out_data = 32'h01FF3CA5; locked=1; sync_err never pulses.
2. Gapped input: repeat scenario 1 with in_valid low on every other cycle. Required response: identical out_data; pulses spaced 16 cycles apart; no bits lost.
3. Missing sync: second frame has frame_sync=0 on its first beat. Required response: sync_err pulses once; locked falls; out_data keeps 32'h01FF3CA5; the next frame_sync relocks, and the next frame's words are all decoded correctly.
4. Early sync: frame_sync asserted at ch 2 bit 3. Required response: sync_err pulses once; no out_valid[2] for the partial word; the following 32 bits decode into ch 0..3 starting at that beat.
5. Pre-lock garbage: 13 random bits with frame_sync=0, then a proper frame. Required response: no out_valid and no sync_err before the sync beat; correct decode after it.
6. Reset mid-frame: assert rst asynchronously (not clock-aligned) at ch 1 bit 4. Required response: all outputs read 0 immediately; after release, the state is HUNT and no spurious out_valid occurs.
